// File: rtl/sos_sequencer_if.sv
// Trigger, generator handshake and shared-pin bundle for sos_sequencer.
// The slave modport is the sequencer's view; master is the trigger/generator side.
interface sos_sequencer_if;
  logic Start_Sig;
  logic S_Start_Sig;
  logic S_Done_Sig;
  logic S_Pin_In;
  logic O_Start_Sig;
  logic O_Done_Sig;
  logic O_Pin_In;
  logic Pin_Out;
  logic Busy_Sig;
  logic Done_Sig;
  logic Err_Sig;

  modport master (
    output Start_Sig, S_Done_Sig, S_Pin_In, O_Done_Sig, O_Pin_In,
    input  S_Start_Sig, O_Start_Sig, Pin_Out, Busy_Sig, Done_Sig, Err_Sig
  );

  modport slave (
    input  Start_Sig, S_Done_Sig, S_Pin_In, O_Done_Sig, O_Pin_In,
    output S_Start_Sig, O_Start_Sig, Pin_Out, Busy_Sig, Done_Sig, Err_Sig
  );
endinterface

// File: rtl/sos_sequencer.sv
// Sequences S, O, S symbol generators onto one active-low pin with timed gaps,
// repeating the word REPEAT times. Define SOS_TIMEOUT_EN for the Done watchdog.
module sos_sequencer #(
  parameter logic [15:0] T1MS        = 16'd49_999,
  parameter logic [9:0]  GAP_MS      = 10'd300,
  parameter logic [9:0]  WORD_GAP_MS = 10'd700,
  parameter logic [3:0]  REPEAT      = 4'd3
`ifdef SOS_TIMEOUT_EN
  , parameter logic [11:0] TIMEOUT_MS = 12'd3000
`endif
) (
  input  logic          CLK,
  input  logic          RSTn,
  sos_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SYM_S1   = 3'd1,
    GAP1     = 3'd2,
    SYM_O    = 3'd3,
    GAP2     = 3'd4,
    SYM_S2   = 3'd5,
    WORD_GAP = 3'd6,
    FINISH   = 3'd7
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic        r_start_prev;
  logic        w_trigger;
  logic [15:0] r_presc;
  logic [9:0]  r_ms;
  logic [9:0]  w_gap_len;
  logic        w_in_gap;
  logic        w_tick;
  logic        w_gap_exit;
  logic [3:0]  r_word_cnt;
  logic [4:0]  w_repeat_eff;
  logic        w_last_word;
  logic        w_timeout;
  logic        w_s_start, w_o_start, w_pin, w_busy, w_done;
  logic        r_s_start, r_o_start, r_pin, r_busy, r_done;

  assign w_trigger    = bus.Start_Sig & ~r_start_prev;
  assign w_repeat_eff = (REPEAT == 4'd0) ? 5'd1 : {1'b0, REPEAT};
  assign w_last_word  = (({1'b0, r_word_cnt} + 5'd1) >= w_repeat_eff);
  assign w_tick       = (r_presc == T1MS);

  always_comb begin
    w_in_gap  = 1'b0;
    w_gap_len = 10'd0;
    case (r_state)
      GAP1, GAP2: begin
        w_in_gap  = 1'b1;
        w_gap_len = GAP_MS;
      end
      WORD_GAP: begin
        w_in_gap  = 1'b1;
        w_gap_len = WORD_GAP_MS;
      end
      default: begin
        w_in_gap  = 1'b0;
        w_gap_len = 10'd0;
      end
    endcase
  end

  // A zero-length gap still occupies its state for a single cycle.
  assign w_gap_exit = (w_gap_len == 10'd0) || (w_tick && (r_ms == (w_gap_len - 10'd1)));

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) r_start_prev <= 1'b0;
    else       r_start_prev <= bus.Start_Sig;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:     if (w_trigger) w_next_state = SYM_S1; else w_next_state = IDLE;
      SYM_S1:   if (bus.S_Done_Sig) w_next_state = GAP1;
                else if (w_timeout) w_next_state = FINISH;
                else w_next_state = SYM_S1;
      GAP1:     if (w_gap_exit) w_next_state = SYM_O; else w_next_state = GAP1;
      SYM_O:    if (bus.O_Done_Sig) w_next_state = GAP2;
                else if (w_timeout) w_next_state = FINISH;
                else w_next_state = SYM_O;
      GAP2:     if (w_gap_exit) w_next_state = SYM_S2; else w_next_state = GAP2;
      SYM_S2:   if (bus.S_Done_Sig) w_next_state = WORD_GAP;
                else if (w_timeout) w_next_state = FINISH;
                else w_next_state = SYM_S2;
      WORD_GAP: if (!w_gap_exit) w_next_state = WORD_GAP;
                else if (w_last_word) w_next_state = FINISH;
                else w_next_state = SYM_S1;
      FINISH:   w_next_state = IDLE;
      default:  w_next_state = IDLE;
    endcase
  end

  // Gap timebase restarts from zero whenever a gap state is entered.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_presc <= 16'd0;
      r_ms    <= 10'd0;
    end else if (!w_in_gap || (w_next_state != r_state)) begin
      r_presc <= 16'd0;
      r_ms    <= 10'd0;
    end else if (w_tick) begin
      r_presc <= 16'd0;
      r_ms    <= r_ms + 10'd1;
    end else begin
      r_presc <= r_presc + 16'd1;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn)                                  r_word_cnt <= 4'd0;
    else if ((r_state == IDLE) && w_trigger)    r_word_cnt <= 4'd0;
    else if ((r_state == WORD_GAP) && w_gap_exit) r_word_cnt <= r_word_cnt + 4'd1;
    else                                        r_word_cnt <= r_word_cnt;
  end

  // Handshake outputs follow the state being entered; the pin is the selected
  // generator's pin delayed by one register stage.
  always_comb begin
    w_s_start = (w_next_state == SYM_S1) || (w_next_state == SYM_S2);
    w_o_start = (w_next_state == SYM_O);
    w_busy    = (w_next_state != IDLE);
    w_done    = (w_next_state == FINISH);
    case (r_state)
      SYM_S1, SYM_S2: w_pin = bus.S_Pin_In;
      SYM_O:          w_pin = bus.O_Pin_In;
      default:        w_pin = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_s_start <= 1'b0;
      r_o_start <= 1'b0;
      r_pin     <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_s_start <= w_s_start;
      r_o_start <= w_o_start;
      r_pin     <= w_pin;
      r_busy    <= w_busy;
      r_done    <= w_done;
    end
  end

  assign bus.S_Start_Sig = r_s_start;
  assign bus.O_Start_Sig = r_o_start;
  assign bus.Pin_Out     = r_pin;
  assign bus.Busy_Sig    = r_busy;
  assign bus.Done_Sig    = r_done;

`ifdef SOS_TIMEOUT_EN
  logic [15:0] r_wd_presc;
  logic [11:0] r_wd_ms;
  logic        w_in_sym;
  logic        w_wd_tick;
  logic        r_err;

  assign w_in_sym  = (r_state == SYM_S1) || (r_state == SYM_O) || (r_state == SYM_S2);
  assign w_wd_tick = (r_wd_presc == T1MS);
  assign w_timeout = w_in_sym && w_wd_tick && (r_wd_ms == (TIMEOUT_MS - 12'd1));

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_wd_presc <= 16'd0;
      r_wd_ms    <= 12'd0;
    end else if (!w_in_sym || (w_next_state != r_state)) begin
      r_wd_presc <= 16'd0;
      r_wd_ms    <= 12'd0;
    end else if (w_wd_tick) begin
      r_wd_presc <= 16'd0;
      r_wd_ms    <= r_wd_ms + 12'd1;
    end else begin
      r_wd_presc <= r_wd_presc + 16'd1;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn)                                  r_err <= 1'b0;
    else if ((r_state == IDLE) && w_trigger)    r_err <= 1'b0;
    else if (w_in_sym && (w_next_state == FINISH)) r_err <= 1'b1;
    else                                        r_err <= r_err;
  end

  assign bus.Err_Sig = r_err;
`else
  assign w_timeout   = 1'b0;
  assign bus.Err_Sig = 1'b0;
`endif

endmodule

// File: tb/tb_sos_sequencer.sv
// Randomized bench for sos_sequencer: a plan-based reference model predicts the
// per-cycle start/pin/busy/done/err vector from each accepted trigger.
module tb_sos_sequencer;
  localparam int T1     = 5;
  localparam int GAPC   = 3 * T1;
  localparam int WGAPC  = 5 * T1;
  localparam int REP    = 3;
  localparam int TO_CYC = 10 * T1;
  localparam int NCYC   = 6000;

  typedef struct {
    int sel;
    bit busy;
    bit done;
    bit err;
  } exp_t;

  logic CLK;
  logic RSTn;
  sos_sequencer_if bus();

  sos_sequencer #(
    .T1MS(16'd4), .GAP_MS(10'd3), .WORD_GAP_MS(10'd5), .REPEAT(4'd3)
`ifdef SOS_TIMEOUT_EN
    , .TIMEOUT_MS(12'd10)
`endif
  ) dut (
    .CLK(CLK),
    .RSTn(RSTn),
    .bus(bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  exp_t exp_q[$];
  int   dly_q[$];
  int   total = 0;
  int   bad = 0;
  int   runs_exp = 0;
  int   done_seen = 0;
  bit   model_err = 1'b0;
  bit   model_prev = 1'b0;
  int   prev_sel = 0;
  bit   prev_spin = 1'b1;
  bit   prev_opin = 1'b1;
  int   s_cnt = 0, s_d = 1, o_cnt = 0, o_d = 1;
  bit   rst_done = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [5:0] outs();
    return {bus.S_Start_Sig, bus.O_Start_Sig, bus.Pin_Out, bus.Busy_Sig, bus.Done_Sig, bus.Err_Sig};
  endfunction

  task automatic push_iv(input int n, input int sel, input bit busy, input bit done, input bit err);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.sel = sel; e.busy = busy; e.done = done; e.err = err;
      exp_q.push_back(e);
    end
  endtask

  function automatic int pick_delay();
`ifdef SOS_TIMEOUT_EN
    if ($urandom_range(0, 7) == 0) return 0;
`endif
    return int'($urandom_range(1, 12));
  endfunction

  // Whole-run plan: S, gap, O, gap, S, word gap per word, then one FINISH cycle.
  task automatic plan_run();
    int d;
    bit stop;
    stop = 1'b0;
    dly_q.delete();
    for (int w = 0; w < REP; w++) begin
      for (int k = 0; k < 3; k++) begin
        d = pick_delay();
        dly_q.push_back(d);
        if (d == 0) begin
          push_iv(TO_CYC, (k == 1) ? 2 : 1, 1'b1, 1'b0, 1'b0);
          stop = 1'b1;
          break;
        end
        push_iv(d, (k == 1) ? 2 : 1, 1'b1, 1'b0, 1'b0);
        push_iv((k < 2) ? GAPC : WGAPC, 0, 1'b1, 1'b0, 1'b0);
      end
      if (stop) break;
    end
    push_iv(1, 0, 1'b1, 1'b1, stop);
  endtask

  initial begin
    exp_t cur;
    bit   nxt;
    bit   exp_pin;
    RSTn = 1'b0;
    bus.Start_Sig = 1'b0;
    bus.S_Done_Sig = 1'b0;
    bus.O_Done_Sig = 1'b0;
    bus.S_Pin_In = 1'b1;
    bus.O_Pin_In = 1'b1;
    repeat (2) @(negedge CLK);
    check_val("reset", outs(), 32'h08);
    RSTn = 1'b1;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge CLK);
      if (exp_q.size() > 0) begin
        cur = exp_q.pop_front();
        if (cur.done) model_err = cur.err;
      end else begin
        cur.sel = 0; cur.busy = 1'b0; cur.done = 1'b0; cur.err = model_err;
      end
      exp_pin = (prev_sel == 1) ? prev_spin : (prev_sel == 2) ? prev_opin : 1'b1;
      check_val("cycle", outs(), {26'd0, cur.sel == 1, cur.sel == 2, exp_pin, cur.busy, cur.done, cur.err});
      if (bus.Done_Sig) done_seen++;

      if (!rst_done && (cyc > 1500) && (cur.sel == 2)) begin
        #2 RSTn = 1'b0;
        #1 check_val("async_rst", outs(), 32'h08);
        bus.Start_Sig = 1'b0;
        bus.S_Done_Sig = 1'b0;
        bus.O_Done_Sig = 1'b0;
        exp_q.delete();
        dly_q.delete();
        runs_exp--;
        model_err = 1'b0;
        model_prev = 1'b0;
        prev_sel = 0;
        s_cnt = 0;
        o_cnt = 0;
        rst_done = 1'b1;
        @(negedge CLK);
        check_val("rst_hold", outs(), 32'h08);
        RSTn = 1'b1;
        continue;
      end

      if (bus.S_Start_Sig) begin
        s_cnt++;
        if (s_cnt == 1) s_d = (dly_q.size() > 0) ? dly_q.pop_front() : 1;
        bus.S_Done_Sig = (s_cnt == s_d);
      end else begin
        s_cnt = 0;
        bus.S_Done_Sig = ($urandom_range(0, 7) == 0);
      end
      if (bus.O_Start_Sig) begin
        o_cnt++;
        if (o_cnt == 1) o_d = (dly_q.size() > 0) ? dly_q.pop_front() : 1;
        bus.O_Done_Sig = (o_cnt == o_d);
      end else begin
        o_cnt = 0;
        bus.O_Done_Sig = ($urandom_range(0, 7) == 0);
      end
      bus.S_Pin_In = 1'($urandom_range(0, 1));
      bus.O_Pin_In = 1'($urandom_range(0, 1));

      // Force a fresh rising edge onto the FINISH cycle, otherwise random toggling.
      if (cyc > NCYC - 400)                         nxt = bus.Start_Sig;
      else if ((exp_q.size() > 0) && exp_q[0].done) nxt = 1'b0;
      else if (cur.done)                            nxt = 1'b1;
      else if ($urandom_range(0, 5) == 0)           nxt = ~bus.Start_Sig;
      else                                          nxt = bus.Start_Sig;

      if (!cur.busy && nxt && !model_prev) begin
        plan_run();
        runs_exp++;
        model_err = 1'b0;
      end
      model_prev = nxt;
      bus.Start_Sig = nxt;
      prev_sel = cur.sel;
      prev_spin = bus.S_Pin_In;
      prev_opin = bus.O_Pin_In;
    end

    check_val("drain", exp_q.size(), 32'd0);
    check_val("done_cnt", done_seen, runs_exp);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sos_sequencer.md
Name: sos_sequencer

Overview:
Controller that sequences one S-symbol generator and one O-symbol generator to emit a complete "S-O-S" distress word on a single shared active-low buzzer/LED pin. It issues level Start/Done handshakes to each generator in order, multiplexes the active generator's pin onto the shared output, inserts timed inter-symbol and inter-word gaps, and repeats the word a programmable number of times. It sits between the top-level trigger (key/debounce) and the symbol generator modules.

Parameters:
T1MS, 16'd49_999, CLK cycles per 1 ms minus 1 (50 MHz)
GAP_MS, 10'd300, inter-symbol gap in ms, pin idle
WORD_GAP_MS, 10'd700, gap after each word, pin idle
REPEAT, 4'd3, number of SOS words per trigger (1..15; 0 treated as 1)
TIMEOUT_MS, 12'd3000, max ms waiting for a generator Done (optional feature)

Ports:
CLK  in  1  system clock
RSTn  in  1  asynchronous active-low reset
Start_Sig  in  1  trigger; rising edge sampled while IDLE
S_Start_Sig  out  1  level start to S generator
S_Done_Sig  in  1  one-cycle done pulse from S generator
S_Pin_In  in  1  S generator pin (active-low)
O_Start_Sig  out  1  level start to O generator
O_Done_Sig  in  1  one-cycle done pulse from O generator
O_Pin_In  in  1  O generator pin (active-low)
Pin_Out  out  1  shared pin, active-low, idle 1
Busy_Sig  out  1  high from accepted trigger until Done_Sig
Done_Sig  out  1  one-cycle pulse after last word
Err_Sig  out  1  sticky timeout flag (optional feature only)

Behaviour:
- Reset (async, RSTn low): state IDLE; S_Start_Sig=0, O_Start_Sig=0, Pin_Out=1, Busy_Sig=0, Done_Sig=0, Err_Sig=0; ms prescaler, ms counter, word counter = 0; Start edge register = 0. Reset mid-word drops all starts immediately.
- Start_Sig registered once; trigger = Start_Sig & !prev. Triggers outside IDLE ignored (not queued).
- 1 ms tick: 16-bit prescaler counts 0..T1MS, runs only in GAP states, cleared on entry to each gap; tick on prescaler==T1MS.
- States: IDLE -> SYM_S1 -> GAP1 -> SYM_O -> GAP2 -> SYM_S2 -> WORD_GAP -> (word_cnt+1 < REPEAT ? SYM_S1 : FINISH) -> IDLE.
- IDLE: on trigger, word_cnt=0, Busy_Sig=1, next SYM_S1 (1 cycle latency trigger->S_Start_Sig high).
- SYM_x: respective Start high; other Start low. Pin_Out = selected generator pin (registered, 1-cycle delay). On its Done pulse, Start drops next cycle, enter gap. Done from the non-selected generator ignored.
- GAP1/GAP2: Pin_Out=1 for exactly GAP_MS ticks; WORD_GAP: WORD_GAP_MS ticks. GAP length 0 = skip state (1 cycle).
- Word counter 4-bit, increments on WORD_GAP exit; compare against REPEAT (0 -> 1).
- FINISH: Done_Sig=1 one cycle, Busy_Sig cleared same edge as return to IDLE. Trigger coinciding with FINISH ignored.
- Both Starts never high simultaneously; Pin_Out=1 whenever neither generator is selected.

Optional Feature:
SOS_TIMEOUT_EN: defined -> 12-bit ms watchdog runs in SYM states (own prescaler), reset on state entry; reaching TIMEOUT_MS drops all starts, sets Err_Sig (sticky until reset or next accepted trigger), goes FINISH (Done_Sig still pulses). Undefined -> no watchdog, Err_Sig tied 0, SYM states wait indefinitely.

Test Plan:
- Reset: drive RSTn=0 mid SYM_O -> all outputs reset values within same cycle, O_Start_Sig=0, Pin_Out=1.
- Single word (T1MS=4, GAP_MS=3, WORD_GAP_MS=5, REPEAT=1), behavioral generators Done after 40 cycles -> start order S,O,S; gaps exactly 15 cycles Pin_Out=1; one Done_Sig pulse; Busy_Sig high throughout.
- REPEAT=3 -> exactly 9 symbol handshakes, 3 word gaps, one Done_Sig.
- Retrigger: pulse Start_Sig during SYM_O and at FINISH cycle -> ignored; held Start_Sig high after completion -> no restart until low-high edge.
- Cross Done: inject O_Done_Sig during SYM_S1 -> no state change.
- SOS_TIMEOUT_EN, TIMEOUT_MS=10, S generator never Done -> after 50 cycles S_Start_Sig=0, Err_Sig=1, Done_Sig pulse; next trigger clears Err_Sig.
